// File: rtl/adc_scan_ctrl.sv
// rtl/adc_scan_ctrl.sv - SPI master and round-robin channel scheduler for an 8-channel 10-bit serial ADC (optional ADC_NULL_CHECK_EN adds frame_err)
module adc_scan_ctrl #(
    parameter int CLK_DIV  = 4,
    parameter int CS_GAP   = 8,
    parameter bit SGL_DIFF = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_en,
    input  logic       trig,
    input  logic [7:0] ch_mask,
    output logic       sclk,
    output logic       cs_n,
    output logic       mosi,
    input  logic       miso,
    output logic [9:0] sample_data,
    output logic [2:0] sample_ch,
    output logic       sample_valid,
    output logic       busy
`ifdef ADC_NULL_CHECK_EN
    ,
    output logic       frame_err
`endif
);

    localparam int MAXC = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_FRAME  = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [2:0]      ch_q, ch_d;
    logic [7:0]      snap_q, snap_d;
    logic [2:0]      start_q, start_d;
    logic            pass_q, pass_d;
    logic            first_q, first_d;
    logic            setup_q, setup_d;
    logic [CW-1:0]   div_q, div_d;
    logic [4:0]      bit_q, bit_d;
    logic            sclk_q, sclk_d;
    logic            cs_n_q, cs_n_d;
    logic            mosi_q, mosi_d;
    logic [9:0]      shift_q, shift_d;
    logic [9:0]      data_q, data_d;
    logic [2:0]      sch_q, sch_d;
    logic            valid_q, valid_d;
`ifdef ADC_NULL_CHECK_EN
    logic            null_q, null_d;
    logic            err_q, err_d;
`endif

    logic [2:0]      sel_ch;
    logic [2:0]      gap_next;
    logic [2:0]      dist_next;
    logic [2:0]      dist_cur;
    logic            remaining;

    // Nearest set bit strictly after p in wrap order; p itself is the last resort.
    function automatic logic [2:0] next_ch(input logic [7:0] m, input logic [2:0] p);
        logic [2:0] idx;
        next_ch = p;
        for (int i = 8; i >= 1; i--) begin
            idx = p + 3'(i);
            if (m[idx]) begin
                next_ch = idx;
            end
        end
    endfunction

    // Command bit presented before rising edge k.
    function automatic logic cmd_bit(input logic [4:0] k, input logic [2:0] ch);
        case (k)
            5'd0:    cmd_bit = 1'b1;
            5'd1:    cmd_bit = SGL_DIFF;
            5'd2:    cmd_bit = ch[2];
            5'd3:    cmd_bit = ch[1];
            5'd4:    cmd_bit = ch[0];
            default: cmd_bit = 1'b0;
        endcase
    endfunction

    assign sel_ch    = next_ch(ch_mask, ptr_q);
    assign gap_next  = next_ch(snap_q, ch_q);
    // A single pass continues while the next channel lies further from the pass start than the current one.
    assign dist_next = gap_next - start_q;
    assign dist_cur  = ch_q - start_q;
    assign remaining = dist_next > dist_cur;

    // Next-state and datapath decode for the whole controller.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        ch_d     = ch_q;
        snap_d   = snap_q;
        start_d  = start_q;
        pass_d   = pass_q;
        first_d  = first_q;
        setup_d  = setup_q;
        div_d    = div_q;
        bit_d    = bit_q;
        sclk_d   = sclk_q;
        cs_n_d   = cs_n_q;
        mosi_d   = mosi_q;
        shift_d  = shift_q;
        data_d   = data_q;
        sch_d    = sch_q;
        valid_d  = 1'b0;
`ifdef ADC_NULL_CHECK_EN
        null_d   = null_q;
        err_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if ((scan_en || trig) && (|ch_mask)) begin
                    state_d = ST_SELECT;
                    pass_d  = ~scan_en;
                    first_d = 1'b1;
                end
            end
            ST_SELECT: begin
                if (|ch_mask) begin
                    ch_d    = sel_ch;
                    ptr_d   = sel_ch;
                    snap_d  = ch_mask;
                    if (first_q) begin
                        start_d = sel_ch;
                    end
                    first_d = 1'b0;
                    state_d = ST_FRAME;
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b0;
                    mosi_d  = 1'b1;
                    setup_d = 1'b1;
                    div_d   = '0;
                    bit_d   = 5'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FRAME: begin
                if (setup_q) begin
                    setup_d = 1'b0;
                    div_d   = '0;
                end else if (div_q != CW'(CLK_DIV - 1)) begin
                    div_d = div_q + 1'b1;
                end else begin
                    div_d = '0;
                    if (!sclk_q) begin
                        if (bit_q == 5'd17) begin
                            // Trailing low half done: release the ADC and publish the sample.
                            cs_n_d  = 1'b1;
                            mosi_d  = 1'b0;
                            state_d = ST_GAP;
                            valid_d = 1'b1;
                            data_d  = shift_q;
                            sch_d   = ch_q;
`ifdef ADC_NULL_CHECK_EN
                            err_d   = null_q;
`endif
                        end else begin
                            sclk_d = 1'b1;
                            if (bit_q >= 5'd7) begin
                                shift_d = {shift_q[8:0], miso};
                            end
`ifdef ADC_NULL_CHECK_EN
                            if (bit_q == 5'd6) begin
                                null_d = miso;
                            end
`endif
                        end
                    end else begin
                        sclk_d = 1'b0;
                        bit_d  = bit_q + 5'd1;
                        mosi_d = cmd_bit(bit_q + 5'd1, ch_q);
                    end
                end
            end
            ST_GAP: begin
                if (div_q != CW'(CS_GAP - 1)) begin
                    div_d = div_q + 1'b1;
                end else begin
                    div_d = '0;
                    if (scan_en && (|ch_mask)) begin
                        state_d = ST_SELECT;
                        pass_d  = 1'b0;
                    end else if (pass_q && remaining) begin
                        state_d = ST_SELECT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset returns every pin to its idle level at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= 3'd7;
            ch_q    <= 3'd0;
            snap_q  <= 8'd0;
            start_q <= 3'd0;
            pass_q  <= 1'b0;
            first_q <= 1'b0;
            setup_q <= 1'b0;
            div_q   <= '0;
            bit_q   <= 5'd0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            shift_q <= 10'd0;
            data_q  <= 10'd0;
            sch_q   <= 3'd0;
            valid_q <= 1'b0;
`ifdef ADC_NULL_CHECK_EN
            null_q  <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ch_q    <= ch_d;
            snap_q  <= snap_d;
            start_q <= start_d;
            pass_q  <= pass_d;
            first_q <= first_d;
            setup_q <= setup_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            mosi_q  <= mosi_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            sch_q   <= sch_d;
            valid_q <= valid_d;
`ifdef ADC_NULL_CHECK_EN
            null_q  <= null_d;
            err_q   <= err_d;
`endif
        end
    end

    assign sclk         = sclk_q;
    assign cs_n         = cs_n_q;
    assign mosi         = mosi_q;
    assign sample_data  = data_q;
    assign sample_ch    = sch_q;
    assign sample_valid = valid_q;
    assign busy         = (state_q != ST_IDLE);
`ifdef ADC_NULL_CHECK_EN
    assign frame_err    = err_q;
`endif

endmodule
